// File: rtl/processor_controller.sv
// processor_controller
//   Multi-cycle control unit for a tiny accumulator-less load/store machine.
//   Fetches 16-bit instructions from a synchronous ROM, latches them into IR,
//   and sequences the datapath (register file, ALU, data memory) through a
//   Moore FSM.
//
// Ports
//   clk_i           system clock, rising edge active
//   rst_i           asynchronous active-high reset
//   im_data_i       instruction ROM read data (valid one cycle after address)
//   pc_addr_o       program counter / instruction ROM address
//   ir_out_o        instruction register
//   state_out_o     current FSM state (debug)
//   d_addr_o        data memory address
//   d_wr_o          data memory write enable
//   rf_s_o          register write-data select (1 = data memory, 0 = ALU)
//   rf_w_addr_o     register file write address
//   rf_w_en_o       register file write enable
//   rf_ra_addr_o    register file port A read address
//   rf_rb_addr_o    register file port B read address
//   alu_s0_o        ALU function (000 pass, 001 add, 010 subtract)
//   halted_o        high while the machine is halted
module processor_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] im_data_i,
  output logic [6:0]  pc_addr_o,
  output logic [15:0] ir_out_o,
  output logic [3:0]  state_out_o,
  output logic [7:0]  d_addr_o,
  output logic        d_wr_o,
  output logic        rf_s_o,
  output logic [3:0]  rf_w_addr_o,
  output logic        rf_w_en_o,
  output logic [3:0]  rf_ra_addr_o,
  output logic [3:0]  rf_rb_addr_o,
  output logic [2:0]  alu_s0_o,
  output logic        halted_o
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_LATCH  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_NOOP   = 4'd4;
  localparam logic [3:0] S_LOAD_A = 4'd5;
  localparam logic [3:0] S_LOAD_B = 4'd6;
  localparam logic [3:0] S_STORE  = 4'd7;
  localparam logic [3:0] S_ADD    = 4'd8;
  localparam logic [3:0] S_SUB    = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  logic [3:0]  state_q, state_d;
  logic [6:0]  pc_q;
  logic [15:0] ir_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and IR only move on the closing edge of LATCH; by then the ROM has
  // had the whole FETCH cycle to present the word addressed by pc_q.
  // The 7-bit increment wraps 127 -> 0 on its own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= 7'd0;
      ir_q <= 16'd0;
    end else if (state_q == S_LATCH) begin
      pc_q <= pc_q + 7'd1;
      ir_q <= im_data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;   // undefined opcodes behave as NOOP
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;       // encodings 11..15 recover via INIT
    endcase
  end

  // Moore outputs. Everything defaults to 0 so that INIT (the reset state)
  // drives no strobes, which is what makes reset quiet the datapath at once.
  always_comb begin
    d_addr_o     = 8'd0;
    d_wr_o       = 1'b0;
    rf_s_o       = 1'b0;
    rf_w_addr_o  = 4'd0;
    rf_w_en_o    = 1'b0;
    rf_ra_addr_o = 4'd0;
    rf_rb_addr_o = 4'd0;
    alu_s0_o     = 3'b000;
    halted_o     = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        d_addr_o = ir_q[11:4];
        rf_s_o   = 1'b1;
      end
      S_LOAD_B: begin
        // Address held from LOAD_A so the memory read data is stable
        // while the register file captures it.
        d_addr_o    = ir_q[11:4];
        rf_s_o      = 1'b1;
        rf_w_addr_o = ir_q[3:0];
        rf_w_en_o   = 1'b1;
      end
      S_STORE: begin
        d_addr_o     = ir_q[11:4];
        d_wr_o       = 1'b1;
        rf_ra_addr_o = ir_q[3:0];
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_o = ir_q[11:8];
        rf_rb_addr_o = ir_q[7:4];
        rf_w_addr_o  = ir_q[3:0];
        rf_w_en_o    = 1'b1;
        alu_s0_o     = (state_q == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_addr_o   = pc_q;
  assign ir_out_o    = ir_q;
  assign state_out_o = state_q;

endmodule

// File: tb/tb_processor_controller.sv
// Testbench for processor_controller. Builds the expected cycle-by-cycle
// trace of every output directly from the instruction list in a ROM model
// and compares it on the falling edge.
module tb_processor_controller;

  logic        clk;
  logic        rst;
  logic [15:0] im_data;
  logic [6:0]  pc_addr;
  logic [15:0] ir_out;
  logic [3:0]  state_out;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_en;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [2:0]  alu_s0;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [0:127];

  typedef struct packed {
    logic [3:0]  state;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    logic        halted;
  } rec_t;

  rec_t exp_q[$];

  processor_controller dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .im_data_i    (im_data),
    .pc_addr_o    (pc_addr),
    .ir_out_o     (ir_out),
    .state_out_o  (state_out),
    .d_addr_o     (d_addr),
    .d_wr_o       (d_wr),
    .rf_s_o       (rf_s),
    .rf_w_addr_o  (rf_w_addr),
    .rf_w_en_o    (rf_w_en),
    .rf_ra_addr_o (rf_ra_addr),
    .rf_rb_addr_o (rf_rb_addr),
    .alu_s0_o     (alu_s0),
    .halted_o     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM: data appears one cycle after the address.
  always @(posedge clk) im_data <= rom[pc_addr];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic rec_t observe();
    rec_t o;
    o.state  = state_out;
    o.pc     = pc_addr;
    o.ir     = ir_out;
    o.d_addr = d_addr;
    o.d_wr   = d_wr;
    o.rf_s   = rf_s;
    o.w_addr = rf_w_addr;
    o.w_en   = rf_w_en;
    o.ra     = rf_ra_addr;
    o.rb     = rf_rb_addr;
    o.alu    = alu_s0;
    o.halted = halted;
    return o;
  endfunction

  // Expected trace: one INIT cycle after reset release, then per instruction
  // FETCH, LATCH, DECODE (IR/PC updated) and the execution cycle(s).
  task automatic build_trace(input int n);
    rec_t        r;
    logic [6:0]  pc;
    logic [15:0] ir;
    exp_q.delete();
    r = '0;
    exp_q.push_back(r);
    pc = 7'd0;
    ir = 16'd0;
    while (exp_q.size() < n) begin
      r = '0; r.pc = pc; r.ir = ir;
      r.state = 4'd1; exp_q.push_back(r);
      r.state = 4'd2; exp_q.push_back(r);
      ir = rom[pc];
      pc = pc + 7'd1;
      r.pc = pc; r.ir = ir;
      r.state = 4'd3; exp_q.push_back(r);
      case (ir[15:12])
        4'h1: begin
          r.state = 4'd7; r.d_addr = ir[11:4]; r.d_wr = 1'b1; r.ra = ir[3:0];
          exp_q.push_back(r);
        end
        4'h2: begin
          r.state = 4'd5; r.d_addr = ir[11:4]; r.rf_s = 1'b1;
          exp_q.push_back(r);
          r.state = 4'd6; r.w_en = 1'b1; r.w_addr = ir[3:0];
          exp_q.push_back(r);
        end
        4'h3, 4'h4: begin
          r.state = (ir[15:12] == 4'h3) ? 4'd8 : 4'd9;
          r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0]; r.w_en = 1'b1;
          r.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
          exp_q.push_back(r);
        end
        4'h5: begin
          r.state = 4'd10; r.halted = 1'b1;
          while (exp_q.size() < n) exp_q.push_back(r);
        end
        default: begin
          r.state = 4'd4;
          exp_q.push_back(r);
        end
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, then compare every output for n cycles against the built trace.
  task automatic run_program(input string name, input int n);
    rec_t o;
    rec_t e;
    build_trace(n);
    do_reset();
    for (int k = 0; k < n; k++) begin
      if (k != 0) @(negedge clk);
      o = observe();
      e = exp_q[k];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got st=%0d pc=%0d ir=%h da=%h dw=%b s=%b wa=%0d we=%b ra=%0d rb=%0d alu=%b h=%b, required st=%0d pc=%0d ir=%h da=%h dw=%b s=%b wa=%0d we=%b ra=%0d rb=%0d alu=%b h=%b",
                 name, k, o.state, o.pc, o.ir, o.d_addr, o.d_wr, o.rf_s, o.w_addr, o.w_en, o.ra, o.rb, o.alu, o.halted,
                 e.state, e.pc, e.ir, e.d_addr, e.d_wr, e.rf_s, e.w_addr, e.w_en, e.ra, e.rb, e.alu, e.halted);
      end
    end
    $display("run %s: %0d cycles compared, errors so far %0d", name, n, errors);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 16'h1002;
    // Assert between edges and look before any clock edge can occur.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_out !== 4'd0 || pc_addr !== 7'd0 || ir_out !== 16'd0 ||
        d_wr !== 1'b0 || rf_w_en !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got st=%0d pc=%0d ir=%h dw=%b we=%b h=%b, required all 0",
               state_out, pc_addr, ir_out, d_wr, rf_w_en, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_init: got state %0d, required 0", state_out);
    end
    @(negedge clk);
    checks++;
    if (state_out !== 4'd1 || pc_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_first_fetch: got state %0d pc %0d, required state 1 pc 0", state_out, pc_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_load();
    clear_rom();
    rom[0] = 16'h2060;
    run_program("load", 20);
  endtask

  task automatic test_alu_store();
    clear_rom();
    rom[0] = 16'h3012;
    rom[1] = 16'h4012;
    rom[2] = 16'h1002;
    rom[3] = 16'hF123;
    rom[4] = 16'h2A5C;
    rom[5] = 16'h5000;
    run_program("alu_store", 50);
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 16'h5000;
    run_program("halt", 30);
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    run_program("pc_wrap", 1 + 130 * 4);
  endtask

  // Reset landing in the middle of a strobe state must kill the strobe
  // immediately and keep it off while reset is held.
  task automatic test_abort(input string name, input logic [15:0] instr, input logic [3:0] target);
    bit found;
    clear_rom();
    rom[0] = instr;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (state_out == target) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_reach: got no state %0d within 20 cycles, required it", name, target);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_out !== 4'd0 || d_wr !== 1'b0 || rf_w_en !== 1'b0 || pc_addr !== 7'd0) begin
      errors++;
      $display("FAIL %s_abort: got st=%0d dw=%b we=%b pc=%0d, required st=0 dw=0 we=0 pc=0",
               name, state_out, d_wr, rf_w_en, pc_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (d_wr !== 1'b0 || rf_w_en !== 1'b0 || state_out !== 4'd0) begin
        errors++;
        $display("FAIL %s_held: got st=%0d dw=%b we=%b, required st=0 dw=0 we=0",
                 name, state_out, d_wr, rf_w_en);
      end
    end
    rst = 1'b0;
    $display("test_abort %s done", name);
  endtask

  task automatic test_random(input int seed_round);
    logic [3:0] op;
    for (int i = 0; i < 128; i++) begin
      // Keep HALT rare so most of the run exercises real instructions.
      op = 4'($urandom_range(0, 15));
      if (op == 4'h5 && $urandom_range(0, 7) != 0) op = 4'h3;
      rom[i] = {op, 12'($urandom)};
    end
    run_program($sformatf("random%0d", seed_round), 600);
  endtask

  initial begin
    rst = 1'b0;
    im_data = 16'h0000;
    clear_rom();
    test_reset();
    test_load();
    test_alu_store();
    test_halt();
    test_pc_wrap();
    test_abort("store", 16'h1002, 4'd7);
    test_abort("load_a", 16'h2060, 4'd5);
    for (int r = 0; r < 3; r++) test_random(r);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
